// File: rtl/tt_lut_pkg.sv
// Shared types and helpers for the truth-table evaluator: FSM state,
// table width, and the saturating increment used by both counters.
package tt_lut_pkg;

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} tt_state_e;

  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction

  // Increments v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v == top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tt_lut_eval_if.sv
// Vector/result stream of the truth-table evaluator, valid/ready on both sides.
interface tt_lut_eval_if #(parameter int N_IN = 3);
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_vec;
  logic            in_chk;
  logic            in_exp;
  logic            out_valid;
  logic            out_ready;
  logic            out_bit;

  modport master (output in_valid, in_vec, in_chk, in_exp, out_ready,
                  input  in_ready, out_valid, out_bit);
  modport slave  (input  in_valid, in_vec, in_chk, in_exp, out_ready,
                  output in_ready, out_valid, out_bit);
endinterface

// File: rtl/tt_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats the increment.
module tt_sat_counter
  import tt_lut_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (clr)   count <= '0;
    else if (inc)   count <= CNT_W'(sat_inc(32'(count), CNT_W));
  end

endmodule

// File: rtl/tt_lut_eval.sv
// Run-time programmable N-input truth-table evaluator: serial table load,
// one-stage valid/ready lookup pipeline, saturating eval/mismatch counters.
module tt_lut_eval
  import tt_lut_pkg::*;
#(
  parameter  int N_IN  = 3,
  parameter  int CNT_W = 16,
  localparam int TT_W  = tt_w(N_IN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_bit,
  input  logic               cfg_last,
  output logic               cfg_err,
  output logic               tt_loaded,
  output logic [TT_W-1:0]    tt_word,
  tt_lut_eval_if.slave       bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   eval_cnt,
  output logic [CNT_W-1:0]   mismatch_cnt
);

  tt_state_e         state, state_nxt;
  logic [N_IN-1:0]   bit_cnt, cur_idx;
  logic [TT_W-2:0]   stage;
  logic [TT_W-1:0]   shifted;
  logic              cfg_acc, in_acc, idx_last, commit, frame_err, tt_hit;

  // A bit accepted outside LOAD always starts a new table at index 0.
  assign cur_idx   = (state == LOAD) ? bit_cnt : '0;
  assign idx_last  = (cur_idx == N_IN'(TT_W - 1));
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign commit    = cfg_acc && cfg_last && idx_last;
  assign frame_err = cfg_acc && (cfg_last != idx_last);
  assign shifted   = {stage, cfg_bit};

  // Reload only once the result stage is empty and nothing is waiting to enter.
  assign cfg_ready    = (state != RUN) || (!bus.out_valid && !bus.in_valid);
  assign bus.in_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
  assign in_acc       = bus.in_valid && bus.in_ready;
  assign tt_loaded    = (state == RUN);
  assign tt_hit       = tt_word[bus.in_vec];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (commit)         state_nxt = RUN;
    else if (frame_err) state_nxt = EMPTY;
    else if (cfg_acc)   state_nxt = LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      stage   <= '0;
      tt_word <= '0;
      cfg_err <= 1'b0;
    end else if (cfg_acc) begin
      stage   <= shifted[TT_W-2:0];
      bit_cnt <= cur_idx + 1'b1;
      if (commit) begin
        tt_word <= shifted;
        cfg_err <= 1'b0;
      end else if (frame_err) begin
        cfg_err <= 1'b1;
      end
    end
  end

  // Result register holds its bit while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_bit   <= 1'b0;
    end else if (in_acc) begin
      bus.out_valid <= 1'b1;
      bus.out_bit   <= tt_hit;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  tt_sat_counter #(.CNT_W(CNT_W)) u_eval_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (in_acc),
    .count (eval_cnt)
  );

  tt_sat_counter #(.CNT_W(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (in_acc && bus.in_chk && (tt_hit != bus.in_exp)),
    .count (mismatch_cnt)
  );

endmodule
